tdc_readout_ctrl: RTL and testbench

TDC_READOUT_CTRL -- requirements
Module: tdc_readout_ctrl

---
 rtl/tdc_readout_pkg.sv | 41 ++++
 rtl/tdc_readout_fifo.sv | 62 ++++++
 rtl/tdc_readout_ctrl.sv | 124 ++++++++++++
 tb/tb_tdc_readout_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/tdc_readout_pkg.sv
// Shared types and word layout for the TDC readout controller.
// Build option: TDC_READOUT_ERRFILTER_EN (see tdc_readout_ctrl).
package tdc_readout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT,
    ST_CAPTURE,
    ST_RST
  } state_t;

  localparam int TOA_W      = 10;
  localparam int TOT_W      = 9;
  localparam int CAL_W      = 10;
  localparam int TOA_LSB    = 0;
  localparam int TOT_LSB    = TOA_LSB + TOA_W;
  localparam int CAL_LSB    = TOT_LSB + TOT_W;
  localparam int TOAERR_BIT = CAL_LSB + CAL_W;
  localparam int TOTERR_BIT = TOAERR_BIT + 1;
  localparam int CALERR_BIT = TOTERR_BIT + 1;
  localparam int WORD_W     = CALERR_BIT + 1;
  localparam int CNT_W      = 16;

  function automatic logic [WORD_W-1:0] pack_word(
    input logic [TOA_W-1:0] toa,
    input logic [TOT_W-1:0] tot,
    input logic [CAL_W-1:0] cal,
    input logic             toa_err,
    input logic             tot_err,
    input logic             cal_err
  );
    return {cal_err, tot_err, toa_err, cal, tot, toa};
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/tdc_readout_fifo.sv
// Show-ahead word buffer: data_o always presents the head entry (zero when empty).
// A push into a full buffer is accepted only when a pop happens in the same cycle.
module tdc_readout_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_CNT);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Depth is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/tdc_readout_ctrl.sv
// TDC measurement sequencer: ARM -> WAIT(LATENCY) -> CAPTURE -> RST, hit words buffered for readout.
// Build option TDC_READOUT_ERRFILTER_EN: hits carrying any error flag are counted but not buffered.
module tdc_readout_ctrl
  import tdc_readout_pkg::*;
#(
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk40,
  input  logic              resetn,
  input  logic              start,
  input  logic              hitFlag,
  input  logic [TOA_W-1:0]  TOA_code,
  input  logic [TOT_W-1:0]  TOT_code,
  input  logic [CAL_W-1:0]  Cal_code,
  input  logic              TOAerr,
  input  logic              TOTerr,
  input  logic              Calerr,
  output logic              tdcEnable,
  output logic              autoReset,
  output logic [WORD_W-1:0] dout,
  output logic              doutValid,
  input  logic              doutReady,
  output logic [CNT_W-1:0]  hitCnt,
  output logic [CNT_W-1:0]  errCnt,
  output logic              busy,
  output logic              overflow
);

  state_t             state_q, state_d;
  logic [3:0]         wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               overflow_q, overflow_d;
  logic               capture;
  logic               hit_valid, any_err, push;
  logic               fifo_full, fifo_empty;
  logic [WORD_W-1:0]  hit_word;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    tdcEnable  = 1'b0;
    autoReset  = 1'b0;
    capture    = 1'b0;
    busy       = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: if (start) state_d = ST_ARM;
      ST_ARM: begin
        tdcEnable  = 1'b1;
        wait_cnt_d = 4'(LATENCY - 1);
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) state_d = ST_CAPTURE;
        else                    wait_cnt_d = wait_cnt_q - 4'd1;
      end
      ST_CAPTURE: begin
        capture = 1'b1;
        state_d = ST_RST;
      end
      ST_RST: begin
        autoReset = 1'b1;
        state_d   = start ? ST_ARM : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign any_err   = TOAerr | TOTerr | Calerr;
  assign hit_valid = capture && hitFlag;
  assign hit_word  = pack_word(TOA_code, TOT_code, Cal_code, TOAerr, TOTerr, Calerr);
`ifdef TDC_READOUT_ERRFILTER_EN
  assign push = hit_valid && !any_err;
`else
  assign push = hit_valid;
`endif

  // A full buffer still accepts a word when the head leaves in the same cycle.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    err_cnt_d  = err_cnt_q;
    overflow_d = overflow_q;
    if (hit_valid)            hit_cnt_d  = sat_inc(hit_cnt_q);
    if (hit_valid && any_err) err_cnt_d  = sat_inc(err_cnt_q);
    if (push && fifo_full && !doutReady) overflow_d = 1'b1;
  end

  always_ff @(posedge clk40 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      hit_cnt_q  <= '0;
      err_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      hit_cnt_q  <= hit_cnt_d;
      err_cnt_q  <= err_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign hitCnt    = hit_cnt_q;
  assign errCnt    = err_cnt_q;
  assign overflow  = overflow_q;
  assign doutValid = !fifo_empty;

  tdc_readout_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(WORD_W)
  ) u_fifo (
    .clk_i  (clk40),
    .rst_ni (resetn),
    .push_i (push),
    .data_i (hit_word),
    .pop_i  (doutReady),
    .data_o (dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

endmodule

// File: tb/tb_tdc_readout_ctrl.sv
// Directed bench for tdc_readout_ctrl: window-level model plus hand-computed spot checks.
// Honours TDC_READOUT_ERRFILTER_EN when the design is built with it.
module tb_tdc_readout_ctrl;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic        clk40 = 1'b0;
  logic        resetn, start, hitFlag, doutReady;
  logic [9:0]  TOA_code, Cal_code;
  logic [8:0]  TOT_code;
  logic        TOAerr, TOTerr, Calerr;
  logic        tdcEnable, autoReset, doutValid, busy, overflow;
  logic [31:0] dout;
  logic [15:0] hitCnt, errCnt;
  logic        do_preload;

  int n_tests = 0;
  int n_fail  = 0;

  tdc_readout_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk40(clk40), .resetn(resetn), .start(start), .hitFlag(hitFlag),
    .TOA_code(TOA_code), .TOT_code(TOT_code), .Cal_code(Cal_code),
    .TOAerr(TOAerr), .TOTerr(TOTerr), .Calerr(Calerr),
    .tdcEnable(tdcEnable), .autoReset(autoReset), .dout(dout),
    .doutValid(doutValid), .doutReady(doutReady), .hitCnt(hitCnt),
    .errCnt(errCnt), .busy(busy), .overflow(overflow)
  );

  always #5 clk40 = ~clk40;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Model: m_phase is -1 when idle, else the cycle index inside the current window.
  int          m_phase;
  logic [31:0] m_q[$];
  logic [15:0] m_hit, m_err;
  logic        m_ovf, m_push, m_err_any;
  logic [31:0] m_word;

  always @(negedge clk40) begin
    if (!resetn) begin
      m_phase = -1;
      m_q.delete();
      m_hit = '0;
      m_err = '0;
      m_ovf = 1'b0;
    end
    if (do_preload) m_hit = 16'hFFFE;
    check("tdcEnable", 32'(tdcEnable), 32'(m_phase == 0));
    check("autoReset", 32'(autoReset), 32'(m_phase == LAT + 2));
    check("busy",      32'(busy),      32'(m_phase >= 0));
    check("doutValid", 32'(doutValid), 32'(m_q.size() > 0));
    check("dout",      dout,           (m_q.size() > 0) ? m_q[0] : 32'h0);
    check("hitCnt",    32'(hitCnt),    32'(m_hit));
    check("errCnt",    32'(errCnt),    32'(m_err));
    check("overflow",  32'(overflow),  32'(m_ovf));
    if (resetn) begin
      m_push    = 1'b0;
      m_err_any = TOAerr | TOTerr | Calerr;
      m_word    = {Calerr, TOTerr, TOAerr, Cal_code, TOT_code, TOA_code};
      if (m_phase == LAT + 1 && hitFlag) begin
        m_hit = sat(m_hit);
        if (m_err_any) m_err = sat(m_err);
`ifdef TDC_READOUT_ERRFILTER_EN
        m_push = !m_err_any;
`else
        m_push = 1'b1;
`endif
      end
      if (m_q.size() > 0 && doutReady) begin
        $display("[TB] pop word %h at %0t", m_q[0], $time);
        void'(m_q.pop_front());
      end
      if (m_push) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_word);
        else                    m_ovf = 1'b1;
      end
      if (m_phase == -1 || m_phase == LAT + 2) m_phase = start ? 0 : -1;
      else                                    m_phase = m_phase + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk40);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; hitFlag = 1'b0; doutReady = 1'b1; do_preload = 1'b0;
    TOA_code = '0; TOT_code = '0; Cal_code = '0; TOAerr = 1'b0; TOTerr = 1'b0; Calerr = 1'b0;
    tick(3);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_dout", dout, 32'h0);
    check("reset_valid", 32'(doutValid), 32'd0);
    resetn = 1'b1;
    tick(1);

    // Back-to-back hit windows with fixed codes.
    TOA_code = 10'd300; TOT_code = 9'd120; Cal_code = 10'd500; hitFlag = 1'b1;
    start = 1'b1;
    tick(1);
    check("first_tdcEnable", 32'(tdcEnable), 32'd1);
    tick(4);
    check("first_valid", 32'(doutValid), 32'd1);
    check("first_word", dout, 32'h0FA1_E12C);
    check("first_hitCnt", 32'(hitCnt), 32'd1);
    check("first_autoReset", 32'(autoReset), 32'd1);
    tick(1);
    check("second_tdcEnable", 32'(tdcEnable), 32'd1);
    tick(9);
    check("three_hits", 32'(hitCnt), 32'd3);
    start = 1'b0;
    tick(3);
    check("idle_busy", 32'(busy), 32'd0);

    // Stalled readout: five hits into a four-deep buffer.
    do_reset();
    doutReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      TOA_code = 10'(i + 1);
      start = 1'b1;
      tick(5);
    end
    start = 1'b0;
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_hitCnt", 32'(hitCnt), 32'd5);
    check("ovf_head", dout, 32'h0FA1_E001);
    doutReady = 1'b1;
    tick(5);
    check("drained", 32'(doutValid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Hit with a TOT encoder error.
    do_reset();
    TOA_code = 10'd300; TOTerr = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    check("err_errCnt", 32'(errCnt), 32'd1);
`ifdef TDC_READOUT_ERRFILTER_EN
    check("err_filtered", 32'(doutValid), 32'd0);
`else
    check("err_word", dout, 32'h4FA1_E12C);
`endif
    TOTerr = 1'b0;
    tick(3);

    // Reset pulse in the middle of WAIT.
    start = 1'b1;
    tick(3);
    resetn = 1'b0;
    #1;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_hitCnt", 32'(hitCnt), 32'd0);
    check("midreset_errCnt", 32'(errCnt), 32'd0);
    check("midreset_autoReset", 32'(autoReset), 32'd0);
    start = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(2);

    // start dropped during WAIT: window completes once.
    start = 1'b1;
    tick(2);
    start = 1'b0;
    tick(3);
    check("drop_autoReset", 32'(autoReset), 32'd1);
    tick(1);
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_autoReset_off", 32'(autoReset), 32'd0);
    tick(2);

    // Saturation from a preloaded hit counter.
    force dut.hit_cnt_q = 16'hFFFE;
    do_preload = 1'b1;
    tick(1);
    release dut.hit_cnt_q;
    do_preload = 1'b0;
    check("preload", 32'(hitCnt), 32'h0000_FFFE);
    start = 1'b1;
    tick(15);
    check("saturated", 32'(hitCnt), 32'h0000_FFFF);
    start = 1'b0;
    tick(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
